// File: rtl/tetris6x6_matrix_scan.sv
// Row-at-a-time LED matrix scanner for the 6x6 Tetris core.
// Frame snapshot, per-row blanking, 16-step duty and game-over blink.
module tetris6x6_matrix_scan #(
  parameter int DWELL_UNIT   = 1,
  parameter int BLANK        = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] row0,
  input  logic [5:0] row1,
  input  logic [5:0] row2,
  input  logic [5:0] row3,
  input  logic [5:0] row4,
  input  logic [5:0] row5,
  input  logic       game_over,
  input  logic [3:0] brightness,
  output logic [5:0] row_sel,
  output logic [5:0] col,
  output logic       frame_start,
  output logic [2:0] scan_row
);

  localparam int DRV  = 16 * DWELL_UNIT;
  localparam int MAXC = (BLANK > DRV) ? BLANK : DRV;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BCW  = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] BL_LAST =
    CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [CW-1:0] DR_LAST = CW'(DRV - 1);
  localparam logic [BCW-1:0] BF_LAST =
    BCW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_BLANK,
    S_DRIVE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hold_q, hold_d;
  logic [5:0][5:0] snap_q, snap_d;
  logic [3:0]      sbr_q, sbr_d;
  logic            soff_q, soff_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic            boff_q, boff_d;
  logic [CW-1:0]   lim;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      row_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= 1'b1;
      snap_q  <= '0;
      sbr_q   <= '0;
      soff_q  <= 1'b0;
      bcnt_q  <= '0;
      boff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      snap_q  <= snap_d;
      sbr_q   <= sbr_d;
      soff_q  <= soff_d;
      bcnt_q  <= bcnt_d;
      boff_q  <= boff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    hold_d  = 1'b0;
    snap_d  = snap_q;
    sbr_d   = sbr_q;
    soff_d  = soff_q;
    bcnt_d  = bcnt_q;
    boff_d  = boff_q;
    unique case (state_q)
      S_LOAD: begin
        // hold_q keeps the first post-reset cycle a visible LOAD
        if (!hold_q) begin
          snap_d  = {row5, row4, row3, row2, row1, row0};
          sbr_d   = brightness;
          row_d   = '0;
          cnt_d   = '0;
          state_d = (BLANK == 0) ? S_DRIVE : S_BLANK;
          if (game_over) begin
            soff_d = boff_q;
            if (bcnt_q == BF_LAST) begin
              bcnt_d = '0;
              boff_d = ~boff_q;
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
            end
          end else begin
            soff_d = 1'b0;
            bcnt_d = '0;
            boff_d = 1'b0;
          end
        end
      end
      S_BLANK: begin
        if (cnt_q == BL_LAST) begin
          cnt_d   = '0;
          state_d = S_DRIVE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRIVE: begin
        if (cnt_q == DR_LAST) begin
          cnt_d = '0;
          if (row_q == 3'd5) begin
            row_d   = '0;
            state_d = S_LOAD;
          end else begin
            row_d   = row_q + 3'd1;
            state_d = (BLANK == 0) ? S_DRIVE : S_BLANK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    lim = CW'((32'(sbr_q) + 32'd1) * 32'(DWELL_UNIT));
    row_sel     = '0;
    col         = '0;
    frame_start = (state_q == S_LOAD) && !hold_q;
    scan_row    = row_q;
    if (state_q == S_DRIVE) begin
      row_sel = 6'b000001 << row_q;
      if (cnt_q < lim && !soff_q) col = snap_q[row_q];
    end
  end

endmodule

// File: tb/tb_tetris6x6_matrix_scan.sv
// Directed bench for tetris6x6_matrix_scan: scan timing, tearing,
// duty, blink and mid-frame reset.
module tb_tetris6x6_matrix_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] r0, r1, r2, r3, r4, r5;
  logic       go;
  logic [3:0] br;
  logic [5:0] rs0, col0, rs1, col1;
  logic       fs0, fs1;
  logic [2:0] sr0, sr1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  tetris6x6_matrix_scan #(
    .DWELL_UNIT(1), .BLANK(2), .BLINK_FRAMES(2)
  ) u0 (
    .clk(clk), .rst(rst),
    .row0(r0), .row1(r1), .row2(r2),
    .row3(r3), .row4(r4), .row5(r5),
    .game_over(go), .brightness(br),
    .row_sel(rs0), .col(col0),
    .frame_start(fs0), .scan_row(sr0)
  );

  tetris6x6_matrix_scan #(
    .DWELL_UNIT(1), .BLANK(0), .BLINK_FRAMES(2)
  ) u1 (
    .clk(clk), .rst(rst),
    .row0(r0), .row1(r1), .row2(r2),
    .row3(r3), .row4(r4), .row5(r5),
    .game_over(go), .brightness(br),
    .row_sel(rs1), .col(col1),
    .frame_start(fs1), .scan_row(sr1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [5:0] rs;
    logic [5:0] cl;
    logic       fs;
    logic [2:0] sr;
  } vec_t;

  vec_t tv[10];
  int   vis[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    tv[0] = '{0,   6'h00, 6'h00, 1'b1, 3'd0};
    tv[1] = '{1,   6'h00, 6'h00, 1'b0, 3'd0};
    tv[2] = '{2,   6'h00, 6'h00, 1'b0, 3'd0};
    tv[3] = '{3,   6'h01, 6'h3f, 1'b0, 3'd0};
    tv[4] = '{18,  6'h01, 6'h3f, 1'b0, 3'd0};
    tv[5] = '{19,  6'h00, 6'h00, 1'b0, 3'd1};
    tv[6] = '{21,  6'h02, 6'h3f, 1'b0, 3'd1};
    tv[7] = '{108, 6'h20, 6'h3f, 1'b0, 3'd5};
    tv[8] = '{109, 6'h00, 6'h00, 1'b1, 3'd0};
    tv[9] = '{218, 6'h00, 6'h00, 1'b1, 3'd0};
    vis = '{1, 1, 0, 0, 1, 1, 0, 1};

    {r0, r1, r2, r3, r4, r5} = {6{6'h3f}};
    go = 1'b0;
    br = 4'd15;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_rs0", 32'(rs0), 32'(0));
    chk("rst_col0", 32'(col0), 32'(0));
    chk("rst_fs0", 32'(fs0), 32'(0));
    chk("rst_sr0", 32'(sr0), 32'(0));
    chk("rst_rs1", 32'(rs1), 32'(0));
    chk("rst_fs1", 32'(fs1), 32'(0));

    rst = 1'b0;
    tick();
    cyc = 0;
    while (1) begin
      foreach (tv[i]) begin
        if (tv[i].c == cyc) begin
          chk("tv_rs", 32'(rs0), 32'(tv[i].rs));
          chk("tv_col", 32'(col0), 32'(tv[i].cl));
          chk("tv_fs", 32'(fs0), 32'(tv[i].fs));
          chk("tv_sr", 32'(sr0), 32'(tv[i].sr));
        end
      end
      chk("fs0_period", 32'(fs0), 32'(cyc % 109 == 0));
      chk("fs1_period", 32'(fs1), 32'(cyc % 97 == 0));
      chk("onehot0", 32'($countones(rs0) <= 1), 32'(1));
      chk("onehot1", 32'($countones(rs1) <= 1), 32'(1));
      if (cyc == 16) chk("b2b_r0", 32'(rs1), 32'(6'h01));
      if (cyc == 17) chk("b2b_r1", 32'(rs1), 32'(6'h02));
      if (cyc == 218) break;
      tick();
    end

    r2 = 6'b000101;
    tick();
    r2 = 6'b111000;
    while (cyc < 436) begin
      if (cyc % 109 >= 39 && cyc % 109 <= 54) begin
        chk("tear_col", 32'(col0),
            32'(cyc < 327 ? 6'b000101 : 6'b111000));
        chk("tear_rs", 32'(rs0), 32'(6'h04));
        chk("tear_sr", 32'(sr0), 32'(2));
      end
      tick();
    end

    br = 4'd3;
    r0 = 6'b100001;
    while (cyc < 545) begin
      if (cyc % 109 >= 3 && cyc % 109 <= 18) begin
        chk("duty_col", 32'(col0),
            32'(cyc % 109 < 7 ? 6'b100001 : 6'b000000));
        chk("duty_rs", 32'(rs0), 32'(6'h01));
      end
      tick();
    end

    br = 4'd15;
    go = 1'b1;
    while (cyc < 13 * 109) begin
      if (cyc == 12 * 109) go = 1'b0;
      if (cyc % 109 == 3) begin
        chk("blink_c0", 32'(col0),
            32'(vis[cyc / 109 - 5] != 0 ? 6'b100001 : 6'b0));
        chk("blink_rs0", 32'(rs0), 32'(6'h01));
      end
      if (cyc % 109 == 108) begin
        chk("blink_c5", 32'(col0),
            32'(vis[cyc / 109 - 5] != 0 ? 6'h3f : 6'h00));
        chk("blink_rs5", 32'(rs0), 32'(6'h20));
      end
      tick();
    end

    while (cyc < 13 * 109 + 60) tick();
    chk("pre_rst_rs", 32'(rs0), 32'(6'h08));
    rst = 1'b1;
    tick();
    chk("mid_rst_rs", 32'(rs0), 32'(0));
    chk("mid_rst_col", 32'(col0), 32'(0));
    chk("mid_rst_sr", 32'(sr0), 32'(0));
    chk("mid_rst_fs", 32'(fs0), 32'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_fs", 32'(fs0), 32'(1));
    chk("post_rst_rs", 32'(rs0), 32'(0));
    tick();
    tick();
    chk("post_rst_blank", 32'(rs0), 32'(0));
    tick();
    chk("post_rst_drv", 32'(rs0), 32'(6'h01));
    chk("post_rst_col", 32'(col0), 32'(6'b100001));
    chk("post_rst_sr", 32'(sr0), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
